// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes and the coin acceptor state type.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    RELEASE,
    FAULT
  } acc_state_e;

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Two-flop synchroniser for one asynchronous sensor line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next values are a straight shift through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the two coin sensors
// and emits one clean coin/reject/jam pulse per physical coin.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       stuck,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW = $clog2(RELEASE_CYCLES) + 1;
  localparam int HW = $clog2(STUCK_CYCLES) + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(STUCK_CYCLES);

  logic       nickel_sync, dime_sync;
  logic [1:0] s;

  acc_state_e    state_d, state_q;
  logic [1:0]    pat_d, pat_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [RW-1:0] rcnt_d, rcnt_q;
  logic [HW-1:0] hold_d, hold_q;
  logic [HW-1:0] hold_nxt;
  logic [1:0]    coin_d, coin_q;
  logic          reject_d, reject_q;
  logic          jam_d, jam_q;
  logic          stuck_d, stuck_q;

  sync2 u_sync_nickel (.clk(clk), .rst_n(rst_n), .d(nickel_raw), .q(nickel_sync));
  sync2 u_sync_dime   (.clk(clk), .rst_n(rst_n), .d(dime_raw),   .q(dime_sync));

  assign s = {dime_sync, nickel_sync};

  // Next-state and pulse generation; pulses default low so each lasts one cycle
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    hold_d   = hold_q;
    hold_nxt = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    jam_d    = 1'b0;
    stuck_d  = stuck_q;

    case (state_q)
      IDLE: begin
        if (s != 2'b00) begin
          pat_d   = s;
          cnt_d   = CW'(1);
          state_d = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (s != pat_q) begin
          // bounce or sensor change: drop the candidate silently
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          // accept_en only matters at this single decision edge
          if (pat_q == 2'b11)  jam_d    = 1'b1;
          else if (!accept_en) reject_d = 1'b1;
          else                 coin_d   = pat_q;
          rcnt_d  = '0;
          hold_d  = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE: begin
        if (s != 2'b00) begin
          // any activity (including a second coin) restarts the all-clear count
          rcnt_d = '0;
          hold_d = hold_nxt;
          if (hold_nxt == HOLD_MAX) begin
            stuck_d = 1'b1;
            state_d = FAULT;
          end
        end else if (rcnt_q >= RCNT_LAST) begin
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end

      FAULT: begin
        // parked until reset; no events are ever produced here
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pat_q    <= 2'b00;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      hold_q   <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      hold_q   <= hold_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
      stuck_q  <= stuck_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign stuck  = stuck_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with default parameters (4/4/64).
module tb_coin_acceptor;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, nickel_raw, dime_raw, accept_en;
  logic [1:0] coin;
  logic       reject, jam, stuck, busy;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(4), .STUCK_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
    .accept_en(accept_en), .coin(coin), .reject(reject), .jam(jam),
    .stuck(stuck), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       n;
    logic       d;
    logic       en;
    int         hold;
    logic [1:0] exp_coin;
    logic       exp_rej;
    logic       exp_jam;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0, n_bad = 0;
  int edge_no, n_coin, n_rej, n_jam, e_coin, e_rej, e_jam, n_multi;
  logic [1:0] v_coin;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    edge_no = 0; n_coin = 0; n_rej = 0; n_jam = 0; n_multi = 0;
    e_coin = -1; e_rej = -1; e_jam = -1; v_coin = COIN_NONE;
  endtask

  // one clock edge, then observe the registered outputs 1ns later
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (coin != COIN_NONE) begin
      n_coin++;
      if (n_coin == 1) begin v_coin = coin; e_coin = edge_no; end
    end
    if (reject) begin n_rej++; if (n_rej == 1) e_rej = edge_no; end
    if (jam)    begin n_jam++; if (n_jam == 1) e_jam = edge_no; end
    if (coin == 2'b11 || (int'(coin != COIN_NONE) + int'(reject) + int'(jam)) > 1) n_multi++;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int bl;
    clear_obs();
    nickel_raw = v.n; dime_raw = v.d; accept_en = v.en;
    repeat (v.hold) step();
    nickel_raw = 1'b0; dime_raw = 1'b0;
    bl = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!busy && bl < 0) bl = i;
    end
    chk({tag, "_coin_cnt"}, n_coin, (v.exp_coin != COIN_NONE) ? 1 : 0);
    if (v.exp_coin != COIN_NONE) begin
      chk({tag, "_coin_val"}, int'(v_coin), int'(v.exp_coin));
      chk({tag, "_coin_edge"}, e_coin, 6);
    end
    chk({tag, "_rej_cnt"}, n_rej, int'(v.exp_rej));
    if (v.exp_rej) chk({tag, "_rej_edge"}, e_rej, 6);
    chk({tag, "_jam_cnt"}, n_jam, int'(v.exp_jam));
    if (v.exp_jam) chk({tag, "_jam_edge"}, e_jam, 6);
    chk({tag, "_exclusive"}, n_multi, 0);
    chk({tag, "_busy_low"}, bl, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    //            n     d     en    hold coin       rej   jam
    vecs[0] = '{1'b1, 1'b0, 1'b1, 10, COIN_5,    1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1,  8, COIN_10,   1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1,  8, COIN_NONE, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0,  8, COIN_NONE, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1,  8, COIN_10,   1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0,  8, COIN_NONE, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0,  8, COIN_NONE, 1'b0, 1'b1};

    rst_n = 1'b0; nickel_raw = 1'b0; dime_raw = 1'b0; accept_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_coin", int'(coin), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_jam", int'(jam), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 7; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

    // dime bounces 1,0,1,0 then settles high: one coin, 6 edges after the final rise
    clear_obs();
    accept_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      dime_raw = (i >= 4) ? 1'b1 : ~i[0];
      step();
    end
    dime_raw = 1'b0;
    repeat (12) step();
    chk("bounce_coin_cnt", n_coin, 1);
    chk("bounce_coin_val", int'(v_coin), int'(COIN_10));
    chk("bounce_coin_edge", e_coin, 10);
    chk("bounce_other", n_rej + n_jam, 0);
    chk("bounce_busy", int'(busy), 0);

    // nickel stuck high for 100 cycles: one coin, then sticky fault
    clear_obs();
    nickel_raw = 1'b1;
    repeat (60) step();
    chk("stuck_early", int'(stuck), 0);
    repeat (40) step();
    chk("stuck_late", int'(stuck), 1);
    chk("stuck_coin_cnt", n_coin, 1);
    chk("stuck_coin_val", int'(v_coin), int'(COIN_5));
    chk("stuck_coin_edge", e_coin, 6);
    nickel_raw = 1'b0;
    repeat (10) step();
    clear_obs();
    dime_raw = 1'b1;
    repeat (8) step();
    dime_raw = 1'b0;
    repeat (12) step();
    chk("fault_events", n_coin + n_rej + n_jam, 0);
    chk("fault_busy", int'(busy), 1);
    chk("fault_stuck_hold", int'(stuck), 1);
    rst_n = 1'b0;
    #1;
    chk("fault_rst_stuck", int'(stuck), 0);
    chk("fault_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply_vec("post_fault", vecs[1]);

    // async reset in the middle of debounce (cnt=2 after edge 4)
    clear_obs();
    nickel_raw = 1'b1;
    repeat (4) step();
    chk("mid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_outs", int'(coin) + int'(reject) + int'(jam) + int'(stuck), 0);
    nickel_raw = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("mid_rst_no_coin", n_coin + n_rej + n_jam, 0);
    apply_vec("post_rst", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
